// File: rtl/example_reg_initiator_pkg.sv
// Types shared by the register-bus initiator: FSM state encoding and the
// command/response payload structs. No ports.
package example_reg_initiator_pkg;

    import example_sv_pkg::*;

    localparam int unsigned cmd_addr_width = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    typedef struct packed {
        logic                      we;
        logic [cmd_addr_width-1:0] addr;
        logic [data_width-1:0]     wdata;
    } cmd_t;

    typedef struct packed {
        logic                  err;
        logic [data_width-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/example_sv_pkg.sv
// Shared register-bus constants: bus address/data widths and the register map.
// No ports; imported by the initiator package, interface and top.
package example_sv_pkg;

    localparam int unsigned addr_width = 3;
    localparam int unsigned data_width = 32;

    localparam logic [addr_width-1:0] reg0_addr = 3'd0;
    localparam logic [addr_width-1:0] reg1_addr = 3'd1;
    localparam logic [addr_width-1:0] reg2_addr = 3'd2;
    localparam logic [addr_width-1:0] reg3_addr = 3'd3;
    localparam logic [addr_width-1:0] reg4_addr = 3'd4;
    localparam logic [addr_width-1:0] reg5_addr = 3'd5;
    localparam logic [addr_width-1:0] reg6_addr = 3'd6;
    localparam logic [addr_width-1:0] reg7_addr = 3'd7;

endpackage

// File: rtl/example_reg_initiator_if.sv
// Command/response handshake plus register-bus signals of the initiator.
// master: the initiator (drives cmd_ready, rsp_*, bus_req/we/addr/wdata).
// slave:  its environment (command source, response sink, register file).
interface example_reg_initiator_if;

    import example_sv_pkg::*;
    import example_reg_initiator_pkg::*;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_we;
    logic [cmd_addr_width-1:0] cmd_addr;
    logic [data_width-1:0]     cmd_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [data_width-1:0]     rsp_rdata;
    logic                      rsp_err;

    logic                      bus_req;
    logic                      bus_we;
    logic [addr_width-1:0]     bus_addr;
    logic [data_width-1:0]     bus_wdata;
    logic                      bus_ack;
    logic [data_width-1:0]     bus_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_ack, bus_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_ack, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/example_reg_timeout.sv
// Wait counter for an outstanding bus request.
// Ports: clk, rst_n; clear (zero the count), enable (count this cycle);
// expired_c is high in the enabled cycle that brings the count to
// TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 never expires.
module example_reg_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] count;

    // Count of waited cycles since the counter was last cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the cycle whose increment reaches the limit, so the owner can
    // let a same-cycle ack take priority
    assign expired_c = (TIMEOUT_CYCLES != 0) && enable &&
                       (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/example_reg_initiator.sv
// Register-bus initiator: accepts one command at a time, runs a single
// request/ack cycle on the register bus (or rejects an out-of-range address),
// and returns a response with read data and an error flag.
// Ports: clk, rst_n (async active-low); ifc (master modport) carrying the
// cmd_* handshake, rsp_* handshake and bus_* register-bus signals.
module example_reg_initiator
    import example_sv_pkg::*;
    import example_reg_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned NUM_REGS       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    example_reg_initiator_if.master ifc
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] RSP  = ST_RSP;

    logic [1:0]            state,       state_nxt;
    logic                  cmd_ready_q, cmd_ready_nxt;
    logic                  bus_req_q,   bus_req_nxt;
    logic                  bus_we_q,    bus_we_nxt;
    logic [addr_width-1:0] bus_addr_q,  bus_addr_nxt;
    logic [data_width-1:0] bus_wdata_q, bus_wdata_nxt;
    logic                  rsp_valid_q, rsp_valid_nxt;
    rsp_t                  rsp_q,       rsp_nxt;

    cmd_t cmd_in_c;
    logic handshake_c;
    logic in_range_c;
    logic tmo_clear_c;
    logic tmo_enable_c;
    logic tmo_expired_c;

    assign cmd_in_c    = '{we: ifc.cmd_we, addr: ifc.cmd_addr, wdata: ifc.cmd_wdata};
    assign handshake_c = (state == IDLE) && cmd_ready_q && ifc.cmd_valid;
    assign in_range_c  = cmd_in_c.addr < cmd_addr_width'(NUM_REGS);

    example_reg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmo_clear_c),
        .enable    (tmo_enable_c),
        .expired_c (tmo_expired_c)
    );

    // Next state and next registered outputs; the bus_* registers double as
    // the command holding registers while a request is outstanding
    always_comb begin
        state_nxt     = state;
        bus_req_nxt   = 1'b0;
        bus_we_nxt    = 1'b0;
        bus_addr_nxt  = '0;
        bus_wdata_nxt = '0;
        rsp_valid_nxt = rsp_valid_q;
        rsp_nxt       = rsp_q;
        tmo_clear_c   = 1'b1;
        tmo_enable_c  = 1'b0;

        case (state)
            IDLE: begin
                if (handshake_c) begin
                    if (in_range_c) begin
                        state_nxt     = REQ;
                        bus_req_nxt   = 1'b1;
                        bus_we_nxt    = cmd_in_c.we;
                        bus_addr_nxt  = cmd_in_c.addr[addr_width-1:0];
                        bus_wdata_nxt = cmd_in_c.wdata;
                    end else begin
                        state_nxt     = RSP;
                        rsp_valid_nxt = 1'b1;
                        rsp_nxt       = '{err: 1'b1, rdata: '0};
                    end
                end
            end
            REQ: begin
                tmo_clear_c  = 1'b0;
                tmo_enable_c = !ifc.bus_ack;
                if (ifc.bus_ack) begin
                    state_nxt     = RSP;
                    rsp_valid_nxt = 1'b1;
                    rsp_nxt.err   = 1'b0;
                    rsp_nxt.rdata = bus_we_q ? '0 : ifc.bus_rdata;
                end else if (tmo_expired_c) begin
                    state_nxt     = RSP;
                    rsp_valid_nxt = 1'b1;
                    rsp_nxt       = '{err: 1'b1, rdata: '0};
                end else begin
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = bus_we_q;
                    bus_addr_nxt  = bus_addr_q;
                    bus_wdata_nxt = bus_wdata_q;
                end
            end
            RSP: begin
                if (ifc.rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_nxt       = '0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                rsp_valid_nxt = 1'b0;
                rsp_nxt       = '0;
            end
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            bus_req_q   <= bus_req_nxt;
            bus_we_q    <= bus_we_nxt;
            bus_addr_q  <= bus_addr_nxt;
            bus_wdata_q <= bus_wdata_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_q       <= rsp_nxt;
        end
    end

    assign ifc.cmd_ready = cmd_ready_q;
    assign ifc.bus_req   = bus_req_q;
    assign ifc.bus_we    = bus_we_q;
    assign ifc.bus_addr  = bus_addr_q;
    assign ifc.bus_wdata = bus_wdata_q;
    assign ifc.rsp_valid = rsp_valid_q;
    assign ifc.rsp_rdata = rsp_q.rdata;
    assign ifc.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_example_reg_initiator.sv
// Self-checking bench for example_reg_initiator: directed corner cases plus
// randomized transactions, each predicted from the transaction rules alone.
module tb_example_reg_initiator;

    import example_sv_pkg::*;

    localparam int TMO  = 16;
    localparam int NREG = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    example_reg_initiator_if ifc();

    example_reg_initiator #(
        .TIMEOUT_CYCLES(TMO),
        .NUM_REGS      (NREG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One full command: offer, bus phase (if any), response hold, consume.
    // ack_at is the index of the bus_req cycle in which the bench acks.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata, input int hold);
        bit          in_range;
        bit          acked;
        int          done_at;
        int          waited;
        logic [31:0] exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;

        // Reference: out-of-range -> error; ack within the limit -> success;
        // otherwise the request times out after TMO cycles
        in_range  = (addr < 32'(NREG));
        acked     = in_range && (ack_at <= TMO - 1);
        done_at   = (ack_at <= TMO - 1) ? ack_at : TMO - 1;
        exp_err   = acked ? 32'd0 : 32'd1;
        exp_rdata = (acked && !we) ? rdata : 32'd0;
        exp_addr  = addr & 32'(NREG - 1);

        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = we;
        ifc.cmd_addr  = addr;
        ifc.cmd_wdata = wdata;
        waited = 0;
        while (!ifc.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.cmd_ready) begin
            check("cmd_ready_wait", 32'(ifc.cmd_ready), 32'd1);
            ifc.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        ifc.cmd_we    = 1'($urandom_range(0, 1));
        ifc.cmd_addr  = $urandom;
        ifc.cmd_wdata = $urandom;
        check("cmd_ready_busy", 32'(ifc.cmd_ready), 32'd0);

        if (in_range) begin
            for (int c = 0; c <= done_at; c++) begin
                if (c > 0) @(negedge clk);
                check("bus_req", 32'(ifc.bus_req), 32'd1);
                check("bus_we", 32'(ifc.bus_we), 32'(we));
                check("bus_addr", 32'(ifc.bus_addr), exp_addr);
                check("bus_wdata", ifc.bus_wdata, wdata);
                check("rsp_valid_early", 32'(ifc.rsp_valid), 32'd0);
                ifc.bus_ack   = (c == ack_at);
                ifc.bus_rdata = (c == ack_at) ? rdata : $urandom;
                @(posedge clk);
            end
            @(negedge clk);
            ifc.bus_ack = 1'b0;
            check("bus_req_drop", 32'(ifc.bus_req), 32'd0);
        end else begin
            check("bus_req_none", 32'(ifc.bus_req), 32'd0);
        end
        check("bus_we_idle", 32'(ifc.bus_we), 32'd0);
        check("bus_wdata_idle", ifc.bus_wdata, 32'd0);
        check("rsp_valid", 32'(ifc.rsp_valid), 32'd1);
        check("rsp_err", 32'(ifc.rsp_err), exp_err);
        check("rsp_rdata", ifc.rsp_rdata, exp_rdata);

        // Hold the response with stray acks on the bus; nothing may change
        for (int h = 0; h < hold; h++) begin
            ifc.bus_ack   = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ifc.bus_rdata = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
            check("hold_rsp_err", 32'(ifc.rsp_err), exp_err);
            check("hold_rsp_rdata", ifc.rsp_rdata, exp_rdata);
            check("hold_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
            check("hold_bus_req", 32'(ifc.bus_req), 32'd0);
        end
        ifc.bus_ack   = 1'b0;
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.rsp_ready = 1'b0;
        check("rsp_consumed", 32'(ifc.rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(ifc.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we;
        logic [31:0] r_addr;
        int          r_ack;
        int          r_hold;

        rst_n         = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_addr  = '0;
        ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = '0;

        // Values held during reset
        #3;
        check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
        check("rst_bus_req", 32'(ifc.bus_req), 32'd0);
        check("rst_bus_we", 32'(ifc.bus_we), 32'd0);
        check("rst_bus_addr", 32'(ifc.bus_addr), 32'd0);
        check("rst_bus_wdata", ifc.bus_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);

        // Directed corner cases
        run_txn(1'b1, 32'd2, 32'h15, 2, $urandom, 1);        // write, rdata reads 0
        run_txn(1'b0, 32'd4, $urandom, 3, 32'hC, 0);          // read, ack after 3
        run_txn(1'b0, 32'd9, $urandom, 0, 32'h0, 2);          // out of range
        run_txn(1'b1, 32'h8000_0000, $urandom, 0, 32'h0, 0);  // far out of range write
        run_txn(1'b0, 32'd5, $urandom, 100, 32'hDEAD, 2);     // timeout, late ack
        run_txn(1'b0, 32'd6, $urandom, TMO - 1, 32'hA5, 5);   // ack on limit cycle
        run_txn(1'b0, 32'd7, $urandom, 0, 32'h1234_5678, 0);  // fastest read

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 32'($urandom_range(0, NREG + 3));
            if ($urandom_range(0, 7) == 0) r_addr = $urandom | 32'h100;
            r_ack  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO - 2, TMO + 4))
                                                 : int'($urandom_range(0, 5));
            r_hold = int'($urandom_range(0, 3));
            run_txn(r_we, r_addr, $urandom, r_ack, $urandom, r_hold);
        end

        // Reset in the middle of a bus request
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_addr  = 32'd3;
        ifc.cmd_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        check("mid_bus_req", 32'(ifc.bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_req", 32'(ifc.bus_req), 32'd0);
        check("mid_rst_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
            check("after_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
            check("after_rst_bus_req", 32'(ifc.bus_req), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
